program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: program address width in bits; legal range 2..16.
REQ-002 Parameter STACK_DEPTH, default 4: number of return-address stack entries; legal range 1..16.
REQ-003 Parameter RESET_VEC, default 0: PC value loaded on reset; ADDR_W bits wide.
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_inc  input  1  increment strobe, active-high.
REQ-007 i_load  input  1  jump strobe; PC <= i_data.
REQ-008 i_call  input  1  call strobe; push return address, PC <= i_data.
REQ-009 i_ret  input  1  return strobe; PC <= popped address.
REQ-010 i_rel  input  1  relative-jump qualifier for i_load; used only under PC_RELATIVE_EN.
REQ-011 i_data  input  ADDR_W  jump/call target, or signed offset for relative jumps.
REQ-012 o_pc  output  ADDR_W  current program address, registered.
REQ-013 o_overflow  output  1  registered; high for one cycle after an increment wraps.
REQ-014 o_stack_full  output  1  high while the stack holds STACK_DEPTH entries.
REQ-015 o_stack_empty  output  1  high while the stack holds 0 entries.
REQ-016 o_stack_err  output  1  one-cycle pulse on a rejected call or return.

Function
REQ-017 Only one operation executes per cycle, with priority i_load > i_call > i_ret > i_inc; lower-priority strobes asserted in the same cycle are ignored.
REQ-018 With no strobe asserted, o_pc, the stack and the entry count hold their values.
REQ-019 Increment: o_pc <= (o_pc + 1) mod 2^ADDR_W.
REQ-020 o_overflow is 1 after an edge only if that edge executed an increment from all-ones to zero; every other edge clears it.
REQ-021 Absolute jump: o_pc <= i_data on the next edge; the stack is unchanged.
REQ-022 Call when not full: push (o_pc + 1) mod 2^ADDR_W, o_pc <= i_data, entry count +1; all in one cycle.
REQ-023 Call when full: no push, o_pc unchanged, o_stack_err = 1 for exactly one cycle.
REQ-024 Return when not empty: o_pc <= top entry, entry count -1; all in one cycle.
REQ-025 Return when empty: o_pc unchanged, o_stack_err = 1 for exactly one cycle.
REQ-026 The stack is LIFO; entry count stays within 0..STACK_DEPTH.
REQ-027 o_stack_full and o_stack_empty are decoded from the registered entry count; no combinational path from any strobe.
REQ-028 o_stack_err is 0 on every cycle without a rejected call or return.
REQ-029 A call from PC all-ones pushes return address 0.

Reset
REQ-030 While i_rst = 1: o_pc = RESET_VEC, entry count = 0, all stack entries = 0, o_overflow = 0, o_stack_err = 0, o_stack_empty = 1, o_stack_full = 0; all strobes are ignored.
REQ-031 Reset asserted mid-operation takes effect immediately, with no dependence on i_clk; the first operation after reset release executes on the first rising edge at which i_rst = 0.

Configuration
REQ-032 Macro PC_RELATIVE_EN defined: i_load with i_rel = 1 sets o_pc <= (o_pc + signed i_data) mod 2^ADDR_W; this does not affect o_overflow.
REQ-033 Macro PC_RELATIVE_EN undefined: i_rel is ignored and every i_load is an absolute jump.

Verification (ADDR_W=8, STACK_DEPTH=4, RESET_VEC=0x00)
REQ-034 Assert i_rst mid-count at o_pc = 0x37 -> o_pc = 0x00 immediately, with no clock edge; o_stack_empty = 1.
REQ-035 Load 0xFE, then increment twice -> o_pc = 0xFF, then 0x00; o_overflow = 1 for exactly the cycle after the wrap.
REQ-036 Five calls from o_pc = 0x10 to targets 0x20, 0x30, 0x40, 0x50, 0x60 -> the first four are accepted and o_stack_full = 1; the fifth pulses o_stack_err and o_pc stays 0x50.
REQ-037 Then five returns -> o_pc = 0x41, 0x31, 0x21, 0x11; the fifth return pulses o_stack_err and o_pc stays 0x11.
REQ-038 i_load = 1, i_call = 1 and i_inc = 1 in the same cycle with i_data = 0x80 -> o_pc = 0x80 and the entry count is unchanged.
REQ-039 With PC_RELATIVE_EN defined, o_pc = 0x05, i_load = 1, i_rel = 1, i_data = 0xFA (-6) -> o_pc = 0xFF and o_overflow = 0.

Source files
------------

// File: rtl/program_sequencer_if.sv
// Strobe/data/status bundle between a sequencer controller (master) and program_sequencer (slave).
interface program_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              i_inc;
  logic              i_load;
  logic              i_call;
  logic              i_ret;
  logic              i_rel;
  logic [ADDR_W-1:0] i_data;
  logic [ADDR_W-1:0] o_pc;
  logic              o_overflow;
  logic              o_stack_full;
  logic              o_stack_empty;
  logic              o_stack_err;

  modport master (
    output i_inc, i_load, i_call, i_ret, i_rel, i_data,
    input  o_pc, o_overflow, o_stack_full, o_stack_empty, o_stack_err
  );

  modport slave (
    input  i_inc, i_load, i_call, i_ret, i_rel, i_data,
    output o_pc, o_overflow, o_stack_full, o_stack_empty, o_stack_err
  );
endinterface

// File: rtl/program_sequencer.sv
// Program counter with increment/jump/call/return and a bounded return-address stack.
// Optional macro PC_RELATIVE_EN: i_load with i_rel adds a signed offset to the PC.
module program_sequencer #(
  parameter int unsigned          ADDR_W      = 8,
  parameter int unsigned          STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]    RESET_VEC   = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  program_sequencer_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  // One operation per cycle, priority load > call > ret > inc.
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    stack_d = stack_q;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    if (bus.i_load) begin
`ifdef PC_RELATIVE_EN
      if (bus.i_rel) begin
        pc_d = ADDR_W'(pc_q + bus.i_data);
      end else begin
        pc_d = bus.i_data;
      end
`else
      pc_d = bus.i_data;
`endif
    end else if (bus.i_call) begin
      if (cnt_q == CNT_W'(STACK_DEPTH)) begin
        err_d = 1'b1;
      end else begin
        stack_d[IDX_W'(cnt_q)] = ADDR_W'(pc_q + 1'b1);
        pc_d                   = bus.i_data;
        cnt_d                  = CNT_W'(cnt_q + 1'b1);
      end
    end else if (bus.i_ret) begin
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        pc_d  = stack_q[IDX_W'(cnt_q - 1'b1)];
        cnt_d = CNT_W'(cnt_q - 1'b1);
      end
    end else if (bus.i_inc) begin
      pc_d  = ADDR_W'(pc_q + 1'b1);
      ovf_d = (pc_q == '1);
    end
    full_d  = (cnt_d == CNT_W'(STACK_DEPTH));
    empty_d = (cnt_d == '0);
  end

`ifndef PC_RELATIVE_EN
  logic unused_rel_c;
  assign unused_rel_c = bus.i_rel;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q    <= RESET_VEC;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      stack_q <= stack_d;
    end
  end

  assign bus.o_pc          = pc_q;
  assign bus.o_overflow    = ovf_q;
  assign bus.o_stack_err   = err_q;
  assign bus.o_stack_full  = full_q;
  assign bus.o_stack_empty = empty_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer (ADDR_W=8, STACK_DEPTH=4, RESET_VEC=0).
module tb_program_sequencer;

  logic clk;
  logic rst;

  program_sequencer_if #(.ADDR_W(8)) bus ();

  program_sequencer #(
    .ADDR_W(8),
    .STACK_DEPTH(4),
    .RESET_VEC(8'h00)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic       ovf;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push(input string name, input logic [7:0] pc, input logic ovf,
                      input logic full, input logic empty, input logic err);
    exp_t e;
    e.name = name; e.pc = pc; e.ovf = ovf; e.full = full; e.empty = empty; e.err = err;
    q.push_back(e);
  endtask

  // Drive one cycle of strobes at the falling edge; expectation applies after the next rising edge.
  task automatic op(input string name, input logic ld, input logic cl, input logic rt,
                    input logic inc, input logic rel, input logic [7:0] data,
                    input logic [7:0] pc, input logic ovf, input logic full,
                    input logic empty, input logic err);
    @(negedge clk);
    bus.i_load = ld; bus.i_call = cl; bus.i_ret = rt; bus.i_inc = inc;
    bus.i_rel = rel; bus.i_data = data;
    push(name, pc, ovf, full, empty, err);
  endtask

  // Monitor: compares after every rising edge, or on demand for asynchronous checks.
  initial begin
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        n_tests++;
        if (bus.o_pc !== e.pc || bus.o_overflow !== e.ovf || bus.o_stack_full !== e.full ||
            bus.o_stack_empty !== e.empty || bus.o_stack_err !== e.err) begin
          n_fail++;
          $display("FAIL %s: got pc=%02h ovf=%b full=%b empty=%b err=%b, expected pc=%02h ovf=%b full=%b empty=%b err=%b",
                   e.name, bus.o_pc, bus.o_overflow, bus.o_stack_full, bus.o_stack_empty,
                   bus.o_stack_err, e.pc, e.ovf, e.full, e.empty, e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.i_load = 0; bus.i_call = 0; bus.i_ret = 0; bus.i_inc = 0; bus.i_rel = 0; bus.i_data = '0;
    #3;
    push("reset_state", 8'h00, 0, 0, 1, 0);
    ->chk_ev;
    op("inc_in_reset", 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_inc = 0;

    // Build some stack state, then reset asynchronously mid-count.
    op("load_30",   1, 0, 0, 0, 0, 8'h30, 8'h30, 0, 0, 1, 0);
    op("call_36",   0, 1, 0, 0, 0, 8'h36, 8'h36, 0, 0, 0, 0);
    op("inc_37",    0, 0, 0, 1, 0, 8'h00, 8'h37, 0, 0, 0, 0);
    @(negedge clk);
    bus.i_inc = 0;
    #2;
    rst = 1'b1;
    push("async_rst", 8'h00, 0, 0, 1, 0);
    ->chk_ev;
    @(negedge clk);
    rst = 1'b0;

    // Wrap and overflow pulse.
    op("load_fe",   1, 0, 0, 0, 0, 8'hFE, 8'hFE, 0, 0, 1, 0);
    op("inc_ff",    0, 0, 0, 1, 0, 8'h00, 8'hFF, 0, 0, 1, 0);
    op("inc_wrap",  0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 1, 0);
    op("idle_ovf",  0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0);

    // Fill the stack, then overflow it.
    op("load_10",   1, 0, 0, 0, 0, 8'h10, 8'h10, 0, 0, 1, 0);
    op("call_20",   0, 1, 0, 0, 0, 8'h20, 8'h20, 0, 0, 0, 0);
    op("call_30",   0, 1, 0, 0, 0, 8'h30, 8'h30, 0, 0, 0, 0);
    op("call_40",   0, 1, 0, 0, 0, 8'h40, 8'h40, 0, 0, 0, 0);
    op("call_50",   0, 1, 0, 0, 0, 8'h50, 8'h50, 0, 1, 0, 0);
    op("call_full", 0, 1, 0, 0, 0, 8'h60, 8'h50, 0, 1, 0, 1);
    op("idle_err",  0, 0, 0, 0, 0, 8'h60, 8'h50, 0, 1, 0, 0);

    // Drain LIFO, then underflow.
    op("ret_41",    0, 0, 1, 0, 0, 8'h00, 8'h41, 0, 0, 0, 0);
    op("ret_31",    0, 0, 1, 0, 0, 8'h00, 8'h31, 0, 0, 0, 0);
    op("ret_21",    0, 0, 1, 0, 0, 8'h00, 8'h21, 0, 0, 0, 0);
    op("ret_11",    0, 0, 1, 0, 0, 8'h00, 8'h11, 0, 0, 1, 0);
    op("ret_empty", 0, 0, 1, 0, 0, 8'h00, 8'h11, 0, 0, 1, 1);
    op("idle_hold", 0, 0, 0, 0, 0, 8'h00, 8'h11, 0, 0, 1, 0);

    // Priority.
    op("ld_cl_inc", 1, 1, 0, 1, 0, 8'h80, 8'h80, 0, 0, 1, 0);
    op("cl_rt_inc", 0, 1, 1, 1, 0, 8'h90, 8'h90, 0, 0, 0, 0);
    op("rt_inc",    0, 0, 1, 1, 0, 8'h00, 8'h81, 0, 0, 1, 0);

    // Call from all-ones pushes 0.
    op("load_ff",   1, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 0, 1, 0);
    op("call_ff",   0, 1, 0, 0, 0, 8'h05, 8'h05, 0, 0, 0, 0);
    op("ret_00",    0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0);

    op("load_05",   1, 0, 0, 0, 0, 8'h05, 8'h05, 0, 0, 1, 0);
`ifdef PC_RELATIVE_EN
    op("rel_m6",    1, 0, 0, 0, 1, 8'hFA, 8'hFF, 0, 0, 1, 0);
`else
    op("rel_ignored", 1, 0, 0, 0, 1, 8'hFA, 8'hFA, 0, 0, 1, 0);
`endif
    op("idle_end",  0, 0, 0, 0, 0, 8'h00,
`ifdef PC_RELATIVE_EN
       8'hFF,
`else
       8'hFA,
`endif
       0, 0, 1, 0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
